// File: rtl/esm_pkg.sv
// Shared definitions for the esm instruction delay stage: NOP word and pointer sizing.
package esm_pkg;

    localparam int ESM_MAX_WORD_W = 256;

    // NOP is all zeros; users slice the low Instruction_word_size bits.
    localparam logic [ESM_MAX_WORD_W-1:0] ESM_NOP = '0;

    function automatic int esm_ptr_width(input int depth);
        return (depth <= 2) ? 1 : $clog2(depth);
    endfunction

endpackage

// File: rtl/esm_ring_mem.sv
// Circular history memory with wrapping write pointer; read data is the entry about to be overwritten.
// Optional even-parity protection per entry when ESM_PARITY_EN is defined.
module esm_ring_mem
    import esm_pkg::*;
#(
    parameter int WORD_W = 16,
    parameter int DEPTH  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [WORD_W-1:0] wr_data,
    output logic [WORD_W-1:0] rd_data
`ifdef ESM_PARITY_EN
    ,
    output logic              parity_err
`endif
);

    localparam int               PTR_W = esm_ptr_width(DEPTH);
    localparam logic [PTR_W-1:0] LAST  = PTR_W'(DEPTH - 1);

    logic [WORD_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  wp;

    assign rd_data = mem[wp];

    always_ff @(posedge clk) begin
        // NOTE: non-blocking updates give read-before-write: rd_data is sampled from the pre-edge entry.
        if (rst) begin
            // NOTE: the memory is reset on purpose so the buffer reads NOP after reset; this rules out RAM macros.
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
            wp <= '0;
        end else begin
            mem[wp] <= wr_data;
            wp      <= (wp == LAST) ? '0 : wp + 1'b1;
        end
    end

`ifdef ESM_PARITY_EN
    logic par_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) par_mem[i] <= 1'b0;
        end else begin
            par_mem[wp] <= ^wr_data;
        end
    end

    assign parity_err = (^rd_data) != par_mem[wp];
`endif

endmodule

// File: rtl/esm.sv
// Fixed-distance instruction delay: Instr_out re-issues Instr_in exactly Mem_depth cycles later.
// Build option ESM_PARITY_EN adds per-entry parity; corrupted words are replaced by NOP.
module esm
    import esm_pkg::*;
#(
    parameter int Instruction_word_size = 16,
    parameter int Mem_depth             = 16
) (
    input  logic [Instruction_word_size-1:0] Instr_in,
    input  logic                             clk,
    input  logic                             rst,
    output logic [Instruction_word_size-1:0] Instr_out
);

    localparam logic [Instruction_word_size-1:0] NOP = ESM_NOP[Instruction_word_size-1:0];

    logic [Instruction_word_size-1:0] rd_data;
    logic [Instruction_word_size-1:0] next_out;

`ifdef ESM_PARITY_EN
    logic parity_err;

    esm_ring_mem #(
        .WORD_W (Instruction_word_size),
        .DEPTH  (Mem_depth)
    ) u_mem (
        .clk        (clk),
        .rst        (rst),
        .wr_data    (Instr_in),
        .rd_data    (rd_data),
        .parity_err (parity_err)
    );

    always_comb begin
        // NOTE: default assignment first so every path drives next_out and no latch is inferred.
        next_out = rd_data;
        if (parity_err) next_out = NOP;
    end
`else
    esm_ring_mem #(
        .WORD_W (Instruction_word_size),
        .DEPTH  (Mem_depth)
    ) u_mem (
        .clk     (clk),
        .rst     (rst),
        .wr_data (Instr_in),
        .rd_data (rd_data)
    );

    always_comb begin
        next_out = rd_data;
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) Instr_out <= NOP;
        else     Instr_out <= next_out;
    end

endmodule

// File: tb/tb_esm.sv
// Self-checking bench for esm: depths 1, 5 and 16 run side by side on one shared input stream.
// A history-of-samples model predicts each output from the sample taken Mem_depth edges earlier.
module tb_esm;

    logic        clk;
    logic        rst;
    logic [15:0] Instr_in;
    logic [15:0] out1, out5, out16;

    esm #(.Instruction_word_size(16), .Mem_depth(1))  dut1  (.Instr_in(Instr_in), .clk(clk), .rst(rst), .Instr_out(out1));
    esm #(.Instruction_word_size(16), .Mem_depth(5))  dut5  (.Instr_in(Instr_in), .clk(clk), .rst(rst), .Instr_out(out5));
    esm #(.Instruction_word_size(16), .Mem_depth(16)) dut16 (.Instr_in(Instr_in), .clk(clk), .rst(rst), .Instr_out(out16));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          checks = 0;
    int          errors = 0;
    int          edge_n = 0;
    int          last_rst = 0;
    logic [15:0] hist [0:1023];
    bit          corrupt16 [int];
    int          depths [3] = '{1, 5, 16};

    // Word visible after edge n: the sample from edge n-d, unless a reset happened at or after it.
    function automatic logic [15:0] model(input int d, input int n);
        if (n - d > last_rst && !(d == 16 && corrupt16.exists(n - d)))
            return hist[n - d];
        return 16'h0000;
    endfunction

    function automatic logic [15:0] dut_out(input int k);
        case (k)
            0:       return out1;
            1:       return out5;
            default: return out16;
        endcase
    endfunction

    // Drive mid-cycle, record the sample at the rising edge, settle just after it.
    task automatic step(input logic r, input logic [15:0] din);
        @(negedge clk);
        rst      = r;
        Instr_in = din;
        @(posedge clk);
        edge_n++;
        hist[edge_n] = din;
        if (r) last_rst = edge_n;
        #1;
    endtask

    task automatic test_reset();
        step(1'b1, 16'($urandom));
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (dut_out(k) !== 16'h0000) begin
                errors++;
                $display("FAIL reset depth=%0d edge=%0d got=%h exp=0000", depths[k], edge_n, dut_out(k));
            end
        end
    endtask

    task automatic test_ramp();
        for (int v = 0; v < 40; v++) begin
            step(1'b0, 16'(v));
            for (int k = 0; k < 3; k++) begin
                checks++;
                if (dut_out(k) !== model(depths[k], edge_n)) begin
                    errors++;
                    $display("FAIL ramp depth=%0d edge=%0d got=%h exp=%h",
                             depths[k], edge_n, dut_out(k), model(depths[k], edge_n));
                end
            end
        end
    endtask

    task automatic test_midstream_reset();
        step(1'b1, 16'hFFFF);
        for (int v = 0; v < 40; v++) begin
            if (v == 9) step(1'b1, 16'hBEEF);
            step(1'b0, 16'(v));
            for (int k = 0; k < 3; k++) begin
                checks++;
                if (dut_out(k) !== model(depths[k], edge_n)) begin
                    errors++;
                    $display("FAIL midstream_reset depth=%0d edge=%0d got=%h exp=%h",
                             depths[k], edge_n, dut_out(k), model(depths[k], edge_n));
                end
            end
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 80; i++) begin
            step(($urandom_range(0, 24) == 0), 16'($urandom));
            for (int k = 0; k < 3; k++) begin
                checks++;
                if (dut_out(k) !== model(depths[k], edge_n)) begin
                    errors++;
                    $display("FAIL random depth=%0d edge=%0d got=%h exp=%h",
                             depths[k], edge_n, dut_out(k), model(depths[k], edge_n));
                end
            end
        end
    endtask

`ifdef ESM_PARITY_EN
    task automatic test_parity();
        int idx;
        step(1'b1, 16'h0000);
        for (int v = 0; v < 24; v++) begin
            step(1'b0, 16'(v));
            if (v == 3) begin
                idx = (edge_n - last_rst - 1) % 16;
                dut16.u_mem.mem[idx] = dut16.u_mem.mem[idx] ^ 16'h0010;
                corrupt16[edge_n] = 1'b1;
            end
            for (int k = 0; k < 3; k++) begin
                checks++;
                if (dut_out(k) !== model(depths[k], edge_n)) begin
                    errors++;
                    $display("FAIL parity depth=%0d edge=%0d got=%h exp=%h",
                             depths[k], edge_n, dut_out(k), model(depths[k], edge_n));
                end
            end
        end
    endtask
`endif

    initial begin
        rst      = 1'b1;
        Instr_in = 16'h0000;
        test_reset();
        test_ramp();
        test_midstream_reset();
        test_random();
`ifdef ESM_PARITY_EN
        test_parity();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
